sod_frame_sequencer: RTL and testbench
======================================

# sod_frame_sequencer

Frame-level controller for the `stuff_or_data` engine. It accepts per-frame descriptors (`pm` slots per frame, `cm` data slots) over a valid/ready handshake and buffers up to two. It drives the engine's `pm`/`cm`/`sof`/`valid_in` so that frames run back-to-back with no idle slot, gated by a downstream slot-opportunity strobe. It also monitors the engine output and checks that each frame delivered exactly `cm` data slots out of `pm`.

## Interface
- `MPT_W`, 8, width of the `pm`/`cm` fields; must match the engine instance.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `desc_valid`  in  1  descriptor offered.
- `desc_pm`  in  MPT_W  slots in the frame.
- `desc_cm`  in  MPT_W  data slots in the frame.
- `desc_ready`  out  1  descriptor FIFO not full (combinational from occupancy).
- `slot_tick`  in  1  one slot opportunity this cycle.
- `sod_pm`, `sod_cm`  out  MPT_W  to engine `pm`/`cm`; registered, stable from LOAD until the next LOAD.
- `sod_sof`  out  1  to engine `sof`.
- `sod_valid`  out  1  to engine `valid_in`.
- `sod_valid_out`, `sod_ds`, `sod_sof_out`  in  1 each  from engine outputs.
- `busy`  out  1  state is not IDLE or FIFO is non-empty.
- `frame_done`  out  1  one-cycle pulse when a checked frame completes.
- `frame_err`  out  1  one-cycle pulse together with `frame_done` when the data count is not equal to `cm`.
- `desc_err`  out  1  one-cycle pulse when a descriptor is rejected.
- `data_cnt`  out  MPT_W  number of `ds`=1 slots in the last completed frame.

## Operation
- **Descriptor FIFO**
  - 2 entries; a descriptor is accepted on `desc_valid & desc_ready`.
  - A descriptor with `pm`==0 or `cm`>`pm` is consumed but not enqueued, and `desc_err` pulses the next cycle.
  - `cm`==0 is legal.
  - Simultaneous push and pop when full is not possible, because `desc_ready`=0 when full. Push and pop in the same cycle at occupancy 1 leaves occupancy at 1.
- **FSM states:** IDLE, LOAD, RUN.
  - IDLE: if the FIFO is non-empty, pop the head into `sod_pm`/`sod_cm` and go to LOAD.
  - LOAD (exactly 1 cycle): `sod_sof`=1 and `sod_valid`=0. Clear the slot counter, load the checker's expected pm/cm, and go to RUN.
  - RUN: `sod_valid` = `slot_tick` (combinational AND with state==RUN). The slot counter increments on each tick.
  - On the tick where counter == `sod_pm`-1 (the last slot): if the FIFO is non-empty, pop and go to LOAD; otherwise go to IDLE.
  - The engine is back in FETCH on the cycle after its last `valid_in`, so LOAD always coincides with engine FETCH.
- **Slot counter:** MPT_W bits, never wraps; it tops out at `pm`-1.
- **Checker**
  - Armed by the first `sod_sof_out` after reset; it ignores all inputs before that.
  - Counts `sod_valid_out` and `sod_valid_out & sod_ds`.
  - On the `sod_valid_out` that brings the slot count to the expected `pm`:
    - register `data_cnt` to the ds count including this slot;
    - pulse `frame_done` next cycle, and `frame_err` if that count ≠ expected `cm`;
    - clear both counts.
  - The completion compare uses the expected registers' old values in the same edge where LOAD overwrites them; this is required and must not be bypassed.
- **Reset**
  - Asserting `rst_n` at any time, including mid-frame: FIFO flushed, FSM to IDLE, checker disarmed.
  - The engine has no reset. The system must hold `sod_valid` at 0 and re-initialise the engine alongside this block; the checker re-arms on the next `sod_sof_out`.

## Timing
- Reset values:
  - `sod_pm`, `sod_cm`, `sod_sof`, `sod_valid`, `busy`, `frame_done`, `frame_err`, `desc_err`, `data_cnt` = 0.
  - `desc_ready` = 1.
- Descriptor accepted at cycle c with FSM idle and FIFO empty: LOAD (`sod_sof`=1) at c+1, first possible `sod_valid` at c+2.
- Last slot tick at cycle t:
  - engine `valid_out` at t+1;
  - next frame LOAD at t+1 if queued;
  - `frame_done` at t+2;
  - next `sod_sof_out` at t+2.
- Back-to-back frames cost exactly one non-slot cycle (LOAD) between frames.
- `slot_tick` outside RUN is ignored; ticks are not queued.

## Test plan
- Desc (pm=4, cm=4), `slot_tick`=1 continuous: `sod_sof` at c+1, `sod_valid` for 4 cycles, all `ds`=1, `frame_done` at t+2, `data_cnt`=4, `frame_err`=0.
- Desc (5, 2), `slot_tick` pattern 1,0,1,0…: `sod_valid` only on ticks, 5 slots issued, 2 `ds`=1 slots, `data_cnt`=2, no error.
- Three descriptors (3,1), (2,2), (1,0) offered back-to-back:
  - `desc_ready` drops after two are queued;
  - frames run with a single LOAD cycle between them;
  - three `frame_done` pulses with `data_cnt` 1, 2, 0.
- Descriptors (0,0) and (8,9) with MPT_W=8: `desc_err` pulses each, no `sod_sof`, FIFO occupancy unchanged.
- Desc (3, 2) with `sod_ds` forced to 0: `frame_done` and `frame_err` both pulse, `data_cnt`=0.
- `rst_n` low during slot 2 of (6,3), then release and send (2,1):
  - all outputs return to reset values;
  - no `frame_done` for the aborted frame;
  - the new frame completes with `data_cnt`=1.

Source files
------------

// File: rtl/sod_frame_sequencer.sv
// Frame sequencer for the stuff_or_data engine: queues frame descriptors, issues
// back-to-back frames paced by slot_tick, and checks each delivered frame's data count.
//
// state  | meaning
// IDLE   | no frame in flight; start the next descriptor as soon as one is available
// LOAD   | one cycle with sof to the engine while it sits in FETCH; no slot issued
// RUN    | one engine slot per slot_tick until pm slots have been issued
module sod_frame_sequencer #(
  parameter int MPT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             desc_valid,
  input  logic [MPT_W-1:0] desc_pm,
  input  logic [MPT_W-1:0] desc_cm,
  output logic             desc_ready,
  input  logic             slot_tick,
  output logic [MPT_W-1:0] sod_pm,
  output logic [MPT_W-1:0] sod_cm,
  output logic             sod_sof,
  output logic             sod_valid,
  input  logic             sod_valid_out,
  input  logic             sod_ds,
  input  logic             sod_sof_out,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic             desc_err,
  output logic [MPT_W-1:0] data_cnt
);

  localparam logic [MPT_W-1:0] ONE = MPT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t           state;
  logic [MPT_W-1:0] slot_cnt;

  logic [MPT_W-1:0] fifo_pm [2];
  logic [MPT_W-1:0] fifo_cm [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       occ;

  logic             desc_acc;
  logic             desc_ok;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             last_slot;
  logic [MPT_W-1:0] head_pm;
  logic [MPT_W-1:0] head_cm;

  logic             armed;
  logic [MPT_W-1:0] exp_pm;
  logic [MPT_W-1:0] exp_cm;
  logic [MPT_W-1:0] chk_slots;
  logic [MPT_W-1:0] chk_ds;
  logic [MPT_W-1:0] ds_total;
  logic             count_en;
  logic             frame_end;

  assign desc_ready = (occ != 2'd2);
  assign desc_acc   = desc_valid & desc_ready;
  assign desc_ok    = (desc_pm != '0) && (desc_cm <= desc_pm);
  assign head_pm    = fifo_pm[rd_ptr];
  assign head_cm    = fifo_cm[rd_ptr];
  assign sod_valid  = (state == S_RUN) & slot_tick;
  assign last_slot  = sod_valid && (slot_cnt == sod_pm - ONE);
  // An idle sequencer with an empty queue starts a fresh descriptor directly,
  // so a lone frame reaches LOAD one cycle after acceptance.
  assign bypass     = (state == S_IDLE) && (occ == 2'd0) && desc_acc && desc_ok;
  assign pop        = (occ != 2'd0) && ((state == S_IDLE) || last_slot);
  assign push       = desc_acc && desc_ok && !bypass;
  assign busy       = (state != S_IDLE) || (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pm[wr_ptr] <= desc_pm;
      fifo_cm[wr_ptr] <= desc_cm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= 2'd0;
      desc_err <= 1'b0;
    end else begin
      desc_err <= desc_acc & ~desc_ok;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      occ <= occ + 2'd1;
      else if (pop && !push) occ <= occ - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sod_pm   <= '0;
      sod_cm   <= '0;
      sod_sof  <= 1'b0;
      slot_cnt <= '0;
    end else begin
      sod_sof <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop || bypass) begin
            sod_pm  <= pop ? head_pm : desc_pm;
            sod_cm  <= pop ? head_cm : desc_cm;
            sod_sof <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          slot_cnt <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (last_slot) begin
            if (pop) begin
              sod_pm  <= head_pm;
              sod_cm  <= head_cm;
              sod_sof <= 1'b1;
              state   <= S_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else if (sod_valid) begin
            slot_cnt <= slot_cnt + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The closing slot of a frame can land on the next frame's LOAD edge; the
  // compare below deliberately sees exp_pm/exp_cm before that edge updates them.
  assign count_en  = (armed | sod_sof_out) & sod_valid_out;
  assign ds_total  = chk_ds + (sod_ds ? ONE : '0);
  assign frame_end = count_en && (chk_slots == exp_pm - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      exp_pm     <= '0;
      exp_cm     <= '0;
      chk_slots  <= '0;
      chk_ds     <= '0;
      data_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (sod_sof_out) armed <= 1'b1;
      if (state == S_LOAD) begin
        exp_pm <= sod_pm;
        exp_cm <= sod_cm;
      end
      if (frame_end) begin
        data_cnt   <= ds_total;
        frame_done <= 1'b1;
        frame_err  <= (ds_total != exp_cm);
        chk_slots  <= '0;
        chk_ds     <= '0;
      end else if (count_en) begin
        chk_slots <= chk_slots + ONE;
        chk_ds    <= ds_total;
      end
    end
  end

endmodule

// File: tb/tb_sod_frame_sequencer.sv
// Bench for sod_frame_sequencer: a behavioural stuff_or_data engine closes the loop,
// directed steps cover timing corners, a random phase is scored against descriptor rules.
module tb_sod_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       desc_valid;
  logic [7:0] desc_pm;
  logic [7:0] desc_cm;
  logic       desc_ready;
  logic       slot_tick;
  logic [7:0] sod_pm;
  logic [7:0] sod_cm;
  logic       sod_sof;
  logic       sod_valid;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic       desc_err;
  logic [7:0] data_cnt;

  logic       eng_vout = 1'b0;
  logic       eng_ds = 1'b0;
  logic       eng_sof_out = 1'b0;
  int         eng_idx = 0;
  int         eng_pm = 0;
  int         eng_cm = 0;
  logic       force_ds0 = 1'b0;
  int         tick_mode = 0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int sof_cyc[$];
  int valid_cyc[$];
  int done_cyc[$];
  int done_cnt[$];
  int done_err[$];
  int de_cyc[$];
  int bad_evt = 0;

  sod_frame_sequencer #(.MPT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_pm(desc_pm), .desc_cm(desc_cm), .desc_ready(desc_ready),
    .slot_tick(slot_tick),
    .sod_pm(sod_pm), .sod_cm(sod_cm), .sod_sof(sod_sof), .sod_valid(sod_valid),
    .sod_valid_out(eng_vout), .sod_ds(eng_ds), .sod_sof_out(eng_sof_out),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .desc_err(desc_err),
    .data_cnt(data_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: spreads cm data slots evenly over pm slots, one cycle of latency.
  function automatic logic ds_for(input int i, input int pm, input int cm);
    if (pm == 0) return 1'b0;
    return (((i + 1) * cm) / pm) != ((i * cm) / pm);
  endfunction

  always @(posedge clk) begin
    eng_sof_out <= sod_sof;
    eng_vout    <= sod_valid;
    eng_ds      <= sod_valid && !force_ds0 && ds_for(eng_idx, eng_pm, eng_cm);
    if (sod_sof) begin
      eng_idx <= 0;
      eng_pm  <= int'(sod_pm);
      eng_cm  <= int'(sod_cm);
    end else if (sod_valid) begin
      eng_idx <= eng_idx + 1;
    end
  end

  initial begin
    slot_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0:       slot_tick = 1'b1;
        1:       slot_tick = ((cyc % 2) == 0);
        2:       slot_tick = ($urandom_range(0, 3) != 0);
        default: slot_tick = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (sod_sof) sof_cyc.push_back(cyc);
    if (sod_valid) valid_cyc.push_back(cyc);
    if (sod_valid && (!slot_tick || sod_sof)) bad_evt++;
    if (frame_err && !frame_done) bad_evt++;
    if (frame_done) begin
      done_cyc.push_back(cyc);
      done_cnt.push_back(int'(data_cnt));
      done_err.push_back(int'(frame_err));
    end
    if (desc_err) de_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic send(input int pm, input int cm, output int acc);
    int tries;
    tries = 0;
    desc_pm = 8'(pm);
    desc_cm = 8'(cm);
    desc_valid = 1'b1;
    #1;
    while (!desc_ready && tries < 200) begin
      @(posedge clk);
      #2;
      tries++;
    end
    check("accept_timeout", tries < 200, 1);
    acc = cyc;
    next_cycle();
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cyc.size() < n && k < budget) begin
      next_cycle();
      k++;
    end
    check("done_timeout", done_cyc.size() >= n, 1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_sod_pm"}, sod_pm, 0);
    check({p, "_sod_cm"}, sod_cm, 0);
    check({p, "_sod_sof"}, sod_sof, 0);
    check({p, "_sod_valid"}, sod_valid, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_frame_done"}, frame_done, 0);
    check({p, "_frame_err"}, frame_err, 0);
    check({p, "_desc_err"}, desc_err, 0);
    check({p, "_data_cnt"}, data_cnt, 0);
    check({p, "_desc_ready"}, desc_ready, 1);
  endtask

  int c1, c2, c3, c4, c5;
  int s0, v0, d0, de0, b0;
  int exp_cm_q[$];
  int exp_derr, exp_slots;

  initial begin
    rst_n = 1'b0;
    desc_valid = 1'b0;
    desc_pm = '0;
    desc_cm = '0;
    @(posedge clk);
    #1;
    check_reset("rst");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Single frame, continuous ticks: LOAD at c+1, slots c+2..c+5, done at t+2.
    tick_mode = 0;
    s0 = sof_cyc.size(); v0 = valid_cyc.size(); d0 = done_cyc.size();
    send(4, 4, c1);
    wait_done(d0 + 1, 60);
    idle(3);
    check("t1_sof_cyc", qat(sof_cyc, s0), c1 + 1);
    check("t1_nvalid", valid_cyc.size() - v0, 4);
    check("t1_first_valid", qat(valid_cyc, v0), c1 + 2);
    check("t1_last_valid", qat(valid_cyc, v0 + 3), c1 + 5);
    check("t1_done_cyc", qat(done_cyc, d0), c1 + 7);
    check("t1_data_cnt", qat(done_cnt, d0), 4);
    check("t1_err", qat(done_err, d0), 0);
    check("t1_busy", busy, 0);

    // Alternating ticks: slots only on ticks, spanning nine cycles.
    tick_mode = 1;
    v0 = valid_cyc.size(); d0 = done_cyc.size(); b0 = bad_evt;
    send(5, 2, c1);
    wait_done(d0 + 1, 80);
    idle(3);
    check("t2_nvalid", valid_cyc.size() - v0, 5);
    check("t2_span", qat(valid_cyc, v0 + 4) - qat(valid_cyc, v0), 8);
    check("t2_bad_evt", bad_evt - b0, 0);
    check("t2_data_cnt", qat(done_cnt, d0), 2);
    check("t2_err", qat(done_err, d0), 0);

    // Three descriptors back-to-back: queue fills, one LOAD cycle between frames.
    tick_mode = 0;
    s0 = sof_cyc.size(); v0 = valid_cyc.size(); d0 = done_cyc.size();
    send(3, 1, c1);
    send(2, 2, c2);
    send(1, 0, c3);
    #1;
    check("t3_ready_full", desc_ready, 0);
    check("t3_acc2", c2, c1 + 1);
    check("t3_acc3", c3, c1 + 2);
    wait_done(d0 + 3, 100);
    idle(3);
    check("t3_sof0", qat(sof_cyc, s0), c1 + 1);
    check("t3_sof1", qat(sof_cyc, s0 + 1), c1 + 5);
    check("t3_sof2", qat(sof_cyc, s0 + 2), c1 + 8);
    check("t3_nvalid", valid_cyc.size() - v0, 6);
    check("t3_done0_cyc", qat(done_cyc, d0), c1 + 6);
    check("t3_done1_cyc", qat(done_cyc, d0 + 1), c1 + 9);
    check("t3_done2_cyc", qat(done_cyc, d0 + 2), c1 + 11);
    check("t3_cnt0", qat(done_cnt, d0), 1);
    check("t3_cnt1", qat(done_cnt, d0 + 1), 2);
    check("t3_cnt2", qat(done_cnt, d0 + 2), 0);
    check("t3_errs", qat(done_err, d0) + qat(done_err, d0 + 1) + qat(done_err, d0 + 2), 0);

    // Illegal descriptors with the queue partly full: rejected, occupancy unchanged.
    tick_mode = 3;
    s0 = sof_cyc.size(); d0 = done_cyc.size(); de0 = de_cyc.size();
    send(2, 1, c1);
    send(4, 2, c2);
    send(0, 0, c3);
    send(8, 9, c4);
    #1;
    check("t4_ready_after_bad", desc_ready, 1);
    send(5, 5, c5);
    #1;
    check("t4_ready_full", desc_ready, 0);
    check("t4_nerr", de_cyc.size() - de0, 2);
    check("t4_err0_cyc", qat(de_cyc, de0), c3 + 1);
    check("t4_err1_cyc", qat(de_cyc, de0 + 1), c4 + 1);
    tick_mode = 0;
    wait_done(d0 + 3, 100);
    idle(3);
    check("t4_nsof", sof_cyc.size() - s0, 3);
    check("t4_cnt0", qat(done_cnt, d0), 1);
    check("t4_cnt1", qat(done_cnt, d0 + 1), 2);
    check("t4_cnt2", qat(done_cnt, d0 + 2), 5);

    // Engine reports no data slots: count mismatch flagged.
    force_ds0 = 1'b1;
    d0 = done_cyc.size();
    send(3, 2, c1);
    wait_done(d0 + 1, 60);
    idle(2);
    force_ds0 = 1'b0;
    check("t5_data_cnt", qat(done_cnt, d0), 0);
    check("t5_err", qat(done_err, d0), 1);

    // Reset during slot 2 of a frame, then a clean frame.
    d0 = done_cyc.size();
    send(6, 3, c1);
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    idle(2);
    rst_n = 1'b1;
    idle(12);
    check("t6_no_done", done_cyc.size() - d0, 0);
    send(2, 1, c1);
    wait_done(d0 + 1, 60);
    idle(2);
    check("t6_data_cnt", qat(done_cnt, d0), 1);
    check("t6_err", qat(done_err, d0), 0);

    // Random descriptors and tick pattern, scored against the descriptor list.
    tick_mode = 2;
    s0 = sof_cyc.size(); v0 = valid_cyc.size(); d0 = done_cyc.size(); de0 = de_cyc.size();
    exp_derr = 0;
    exp_slots = 0;
    for (int k = 0; k < 30; k++) begin
      int pm, cm, a;
      if ($urandom_range(0, 5) == 0) begin
        pm = $urandom_range(0, 3);
        cm = pm + $urandom_range(1, 3);
        if ($urandom_range(0, 1) == 0) begin
          pm = 0;
          cm = 0;
        end
      end else begin
        pm = $urandom_range(1, 8);
        cm = $urandom_range(0, pm);
      end
      send(pm, cm, a);
      if (pm != 0 && cm <= pm) begin
        exp_cm_q.push_back(cm);
        exp_slots += pm;
      end else begin
        exp_derr++;
      end
      idle($urandom_range(0, 3));
    end
    wait_done(d0 + exp_cm_q.size(), 3000);
    idle(4);
    check("rnd_ndone", done_cyc.size() - d0, exp_cm_q.size());
    check("rnd_nsof", sof_cyc.size() - s0, exp_cm_q.size());
    check("rnd_nvalid", valid_cyc.size() - v0, exp_slots);
    check("rnd_ndesc_err", de_cyc.size() - de0, exp_derr);
    for (int i = 0; i < exp_cm_q.size(); i++) begin
      check($sformatf("rnd_cnt%0d", i), qat(done_cnt, d0 + i), exp_cm_q[i]);
      check($sformatf("rnd_err%0d", i), qat(done_err, d0 + i), 0);
    end
    check("bad_events", bad_evt, 0);
    check("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
